m_iter_unit: RTL and testbench



---
 rtl/m_pkg.sv | 36 +++
 rtl/m_div_core.sv | 55 +++++
 rtl/m_iter_unit.sv | 149 ++++++++++++++
 tb/tb_m_iter_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/m_pkg.sv
// Shared types, decode constants and operand helpers for the iterative M-extension unit.
package m_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  function automatic logic is_mul(input logic [2:0] f3);
    return !f3[2];
  endfunction

  // op_b selects rs2 (1) or rs1 (0); MULHSU treats only rs1 as signed.
  function automatic logic is_signed(input logic [2:0] f3, input logic op_b);
    case (f3)
      F3_MULH, F3_DIV, F3_REM: return 1'b1;
      F3_MULHSU:               return !op_b;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/m_div_core.sv
// Restoring unsigned divider, one quotient bit per cycle; done flags the final iteration.
module m_div_core import m_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] quo_q, rem_q, div_q;
  logic [CW-1:0]   cnt_q;
  logic            run_q;
  logic [XLEN:0]   rem_sh, diff;
  logic            ge;

  // The dividend shifts out of quo_q while quotient bits shift in from the bottom.
  assign rem_sh    = {rem_q, quo_q[XLEN-1]};
  assign diff      = rem_sh - {1'b0, div_q};
  assign ge        = !diff[XLEN];
  assign done      = run_q && (cnt_q == CW'(XLEN-1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      quo_q <= dividend;
      rem_q <= '0;
      div_q <= divisor;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (abort) begin
      run_q <= 1'b0;
    end else if (run_q) begin
      quo_q <= {quo_q[XLEN-2:0], ge};
      rem_q <= ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
      cnt_q <= cnt_q + 1'b1;
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/m_iter_unit.sv
// Iterative RV32M/RV64M PCPI co-processor: shift-add multiplier inline, restoring divider in m_div_core.
module m_iter_unit import m_pkg::*; #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wait,
  output logic            pcpi_ready,
  output logic            pcpi_busy
);

  // Handshake: pcpi_valid is held by the CPU until pcpi_ready; ready/wr pulse for exactly
  // one cycle with pcpi_rd; dropping valid while iterating abandons the operation silently.

  localparam int N  = XLEN / MUL_STEP;
  localparam int CW = $clog2(XLEN);

  state_t state, state_nxt;

  logic [2:0]          f3_in, f3_q;
  logic                is_m, accept, sa, sb, div_zero, div_ovf, special;
  logic [XLEN-1:0]     mag_a, mag_b, spec_val;
  logic [XLEN-1:0]     a_q, b_q, spec_q, rd_q, result;
  logic [2*XLEN-1:0]   acc_q, prod_fix;
  logic [CW-1:0]       cnt_q;
  logic                neg_q, special_q;
  logic [XLEN+MUL_STEP-1:0]   partial;
  logic [2*XLEN+MUL_STEP-1:0] mul_sum;
  logic [XLEN-1:0]     quo, rem, q_fix, r_fix;
  logic                div_start, div_done, div_abort;
  logic                unused_bits;

  assign f3_in  = pcpi_insn[14:12];
  assign is_m   = (pcpi_insn[6:0] == OPCODE_OP) && (pcpi_insn[31:25] == FUNCT7_MULDIV);
  assign accept = (state == IDLE) && pcpi_valid && is_m;

  assign sa    = is_signed(f3_in, 1'b0) && pcpi_rs1[XLEN-1];
  assign sb    = is_signed(f3_in, 1'b1) && pcpi_rs2[XLEN-1];
  assign mag_a = sa ? -pcpi_rs1 : pcpi_rs1;
  assign mag_b = sb ? -pcpi_rs2 : pcpi_rs2;

  assign div_zero = (pcpi_rs2 == '0);
  assign div_ovf  = is_signed(f3_in, 1'b1) && (pcpi_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                    && (pcpi_rs2 == '1);
  assign special  = !is_mul(f3_in) && (div_zero || div_ovf);
  // f3_in[1] distinguishes REM/REMU from DIV/DIVU.
  assign spec_val = div_zero ? (f3_in[1] ? pcpi_rs1 : '1) : (f3_in[1] ? '0 : pcpi_rs1);

  // Right-shifting accumulator: each slice product enters at bit XLEN, then everything shifts down.
  assign partial = {{MUL_STEP{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q[MUL_STEP-1:0]};
  assign mul_sum = {{MUL_STEP{1'b0}}, acc_q} + {partial, {XLEN{1'b0}}};

  assign div_start = accept && !is_mul(f3_in) && !special;
  assign div_abort = (state == DIV) && !pcpi_valid;

  m_div_core #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .abort     (div_abort),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (quo),
    .remainder (rem),
    .done      (div_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = is_mul(f3_in) ? MUL : (special ? DONE : DIV);
      MUL:  if (!pcpi_valid) state_nxt = IDLE;
            else if (cnt_q == CW'(N-1)) state_nxt = DONE;
      DIV:  if (!pcpi_valid) state_nxt = IDLE;
            else if (div_done) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    q_fix    = neg_q ? -quo : quo;
    r_fix    = neg_q ? -rem : rem;
    result   = '0;
    if (special_q) begin
      result = spec_q;
    end else begin
      case (f3_q)
        F3_MUL:                       result = prod_fix[XLEN-1:0];
        F3_MULH, F3_MULHSU, F3_MULHU: result = prod_fix[2*XLEN-1:XLEN];
        F3_DIV, F3_DIVU:              result = q_fix;
        default:                      result = r_fix;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      f3_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      spec_q    <= '0;
      rd_q      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          f3_q      <= f3_in;
          a_q       <= mag_a;
          b_q       <= mag_b;
          acc_q     <= '0;
          cnt_q     <= '0;
          neg_q     <= (f3_in[2] && f3_in[1]) ? sa : (sa ^ sb);
          special_q <= special;
          spec_q    <= spec_val;
        end
        MUL: begin
          acc_q <= mul_sum[2*XLEN+MUL_STEP-1:MUL_STEP];
          b_q   <= b_q >> MUL_STEP;
          cnt_q <= cnt_q + 1'b1;
        end
        DONE: rd_q <= result;
        default: ;
      endcase
    end
  end

  assign pcpi_ready = (state == DONE);
  assign pcpi_wr    = (state == DONE);
  assign pcpi_wait  = (state != IDLE);
  assign pcpi_busy  = (state != IDLE);
  assign pcpi_rd    = (state == DONE) ? result : rd_q;

  assign unused_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7], mul_sum[MUL_STEP-1:0]};

endmodule

// File: tb/tb_m_iter_unit.sv
// Directed bench for m_iter_unit (XLEN=32, MUL_STEP=1) with an expected-result queue.
module tb_m_iter_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            pcpi_valid;
  logic [31:0]     pcpi_insn;
  logic [XLEN-1:0] pcpi_rs1, pcpi_rs2;
  logic            pcpi_wr, pcpi_wait, pcpi_ready, pcpi_busy;
  logic [XLEN-1:0] pcpi_rd;

  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] last_rd;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  m_iter_unit #(.XLEN(XLEN), .MUL_STEP(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready),
    .pcpi_busy  (pcpi_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_insn(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // Issues one M instruction in cycle 0, checks wait/busy until ready, latency, wr and the popped result.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int lat);
    logic seen;
    logic [XLEN-1:0] want;
    seen = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_idle"}, {pcpi_ready, pcpi_busy}, 2'b00);
    chk({tag, "_rd_hold"}, pcpi_rd, last_rd);
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(f3);
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    exp_q.push_back(exp);
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk); #1;
      if (pcpi_ready) begin
        seen = 1'b1;
        chk({tag, "_latency"}, cyc, lat);
        chk({tag, "_wr"}, pcpi_wr, 1'b1);
        chk({tag, "_queue"}, exp_q.size() > 0, 1'b1);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk({tag, "_rd"}, pcpi_rd, want);
        last_rd = want;
        pcpi_valid = 1'b0;
        break;
      end
      chk({tag, "_wait_busy"}, {pcpi_wait, pcpi_busy, pcpi_wr}, 3'b110);
    end
    chk({tag, "_ready_seen"}, seen, 1'b1);
    if (!seen) pcpi_valid = 1'b0;
  endtask

  initial begin
    logic [XLEN-1:0] ra, rb;
    logic [63:0] p;
    logic any;
    reset = 1'b1; pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
    last_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {pcpi_wr, pcpi_ready, pcpi_wait, pcpi_busy}, 4'b0000);
    chk("reset_rd", pcpi_rd, 32'h0);
    reset = 1'b0;

    run_op("mul_neg",  3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulh",     3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhu",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulhsu",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_op("div_neg",  3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem_neg",  3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu",     3'd5, 32'd100,      32'd7,        32'd14,       33);
    run_op("remu",     3'd7, 32'd100,      32'd7,        32'd2,        33);
    run_op("div_by0",  3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("rem_by0",  3'd6, 32'd5,        32'd0,        32'd5,        1);
    run_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1);

    // Unsigned random operands against the bench's own 64-bit arithmetic.
    for (int i = 0; i < 3; i++) begin
      ra = $urandom();
      rb = $urandom_range(32'hFFFF, 1);
      p  = {32'h0, ra} * {32'h0, rb};
      run_op("rnd_mul",   3'd0, ra, rb, p[31:0], 33);
      run_op("rnd_mulhu", 3'd3, ra, rb, p[63:32], 33);
      run_op("rnd_divu",  3'd5, ra, rb, ra / rb, 33);
      run_op("rnd_remu",  3'd7, ra, rb, ra % rb, 33);
    end

    // Non-M instruction (ADD) held for 40 cycles must never be claimed.
    @(posedge clk); #1;
    pcpi_valid = 1'b1;
    pcpi_insn  = 32'h002081B3;
    any = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      any = any | pcpi_wait | pcpi_ready | pcpi_wr | pcpi_busy;
    end
    chk("non_m_ignored", any, 1'b0);
    chk("non_m_rd", pcpi_rd, last_rd);
    pcpi_valid = 1'b0;

    // DIVU abandoned by dropping valid in cycle 10.
    @(posedge clk); #1;
    pcpi_valid = 1'b1; pcpi_insn = mk_insn(3'd5); pcpi_rs1 = 32'd1000; pcpi_rs2 = 32'd3;
    any = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
      any = any | pcpi_ready;
    end
    pcpi_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", {pcpi_busy, pcpi_wait}, 2'b00);
    for (int cyc = 0; cyc < 30; cyc++) begin
      any = any | pcpi_ready | pcpi_wr;
      @(posedge clk); #1;
    end
    chk("abort_no_ready", any, 1'b0);
    chk("abort_rd", pcpi_rd, last_rd);
    run_op("mul_after_abort", 3'd0, 32'd3, 32'd4, 32'd12, 33);

    // Reset in cycle 5 of a DIV.
    @(posedge clk); #1;
    pcpi_valid = 1'b1; pcpi_insn = mk_insn(3'd4); pcpi_rs1 = 32'd77; pcpi_rs2 = 32'd5;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset_outputs", {pcpi_wr, pcpi_ready, pcpi_wait, pcpi_busy}, 4'b0000);
    chk("midreset_rd", pcpi_rd, 32'h0);
    reset = 1'b0;
    pcpi_valid = 1'b0;
    last_rd = '0;
    run_op("mulhu_after_reset", 3'd3, 32'd2, 32'd3, 32'd0, 33);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
